// File: rtl/i_ddr_deser.sv
// ============================================================================
// Module   : i_ddr_deser
// Purpose  : Packs I_DDR bit-pairs LSB-first into WIDTH-bit words with
//            pair-granular bitslip, valid/ready output and sticky overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i_ddr_deser #(
   parameter int WIDTH = 8
) (
   input  logic             C,
   input  logic             R,
   input  logic             E,
   input  logic [1:0]       D,
   input  logic             BITSLIP,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VALID,
   input  logic             Q_READY,
   output logic             OVERFLOW
);

   localparam int c_PAIRS = WIDTH / 2;
   localparam int c_CW    = (c_PAIRS > 1) ? $clog2(c_PAIRS) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_PAIRS - 1);

   logic [WIDTH-1:0] r_sr;
   logic [c_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_q;
   logic             r_qv;
   logic             r_ov;

   logic             w_accept;
   logic             w_last;
   logic             w_complete;
   logic [WIDTH-1:0] w_word;

   // A bitslip pulse swallows the current pair, shifting alignment by one pair.
   assign w_accept   = E & ~BITSLIP;
   assign w_last     = (r_cnt == c_LAST);
   assign w_complete = w_accept & w_last;
   assign w_word     = {D, r_sr[WIDTH-1:2]};

   always_ff @(posedge C) begin
      if (!R) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_q   <= '0;
         r_qv  <= 1'b0;
         r_ov  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_sr  <= w_word;
            r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
         end
         if (w_complete) begin
            // Load when the slot is empty or being consumed on this same edge.
            if (!r_qv || Q_READY) begin
               r_q  <= w_word;
               r_qv <= 1'b1;
            end else begin
               r_ov <= 1'b1;
            end
         end else if (r_qv && Q_READY) begin
            r_qv <= 1'b0;
         end
      end
   end

   assign Q        = r_q;
   assign Q_VALID  = r_qv;
   assign OVERFLOW = r_ov;

endmodule

`default_nettype wire

// File: tb/tb_i_ddr_deser.sv
// ============================================================================
// Module   : tb_i_ddr_deser
// Purpose  : Scoreboard bench for i_ddr_deser (WIDTH=8) with a pair-queue
//            reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i_ddr_deser;

   localparam int WIDTH = 8;
   localparam int PAIRS = WIDTH / 2;

   logic             C;
   logic             R;
   logic             E;
   logic [1:0]       D;
   logic             BITSLIP;
   logic [WIDTH-1:0] Q;
   logic             Q_VALID;
   logic             Q_READY;
   logic             OVERFLOW;

   int tests;
   int fails;

   // reference model state
   int               pq[$];
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] mq;
   logic             mqv;
   logic             mov;

   i_ddr_deser #(.WIDTH(WIDTH)) dut (
      .C(C), .R(R), .E(E), .D(D), .BITSLIP(BITSLIP),
      .Q(Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY), .OVERFLOW(OVERFLOW)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word = pairs placed at 2-bit slots in arrival order, first pair lowest.
   task automatic model_step(input logic r, input logic e, input logic [1:0] d,
                             input logic bs, input logic rdy);
      int  w;
      bit  done;
      done = 0;
      w    = 0;
      if (!r) begin
         pq.delete();
         exp_q.delete();
         mq  = '0;
         mqv = 1'b0;
         mov = 1'b0;
      end else begin
         if (e && !bs) begin
            pq.push_back(int'(d));
            if (pq.size() == PAIRS) begin
               for (int i = 0; i < PAIRS; i++) w += pq[i] * (4 ** i);
               pq.delete();
               done = 1;
            end
         end
         if (done) begin
            if (!mqv || rdy) begin
               mq  = WIDTH'(w);
               mqv = 1'b1;
               exp_q.push_back(WIDTH'(w));
            end else begin
               mov = 1'b1;
            end
         end else if (mqv && rdy) begin
            mqv = 1'b0;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic [1:0] d,
                      input logic bs, input logic rdy);
      R = r; E = e; D = d; BITSLIP = bs; Q_READY = rdy;
      @(posedge C);
      model_step(r, e, d, bs, rdy);
      #1;
   endtask

   // Monitor: compare outputs each cycle and pop a word on every handshake.
   always @(negedge C) begin
      if (R !== 1'bx) begin
         chk("q_valid", int'(Q_VALID), int'(mqv));
         chk("overflow", int'(OVERFLOW), int'(mov));
         chk("q_hold", int'(Q), int'(mq));
         if (Q_VALID === 1'b1 && Q_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL handshake: got word 0x%0h expected none queued", Q);
            end else begin
               chk("scoreboard", int'(Q), int'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [1:0] pat[4];
      tests = 0; fails = 0;
      mq = '0; mqv = 1'b0; mov = 1'b0;
      R = 1'bx; E = 1'b0; D = 2'b00; BITSLIP = 1'b0; Q_READY = 1'b0;
      pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;

      // reset with random inputs
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
         chk("rst_q", int'(Q), 0);
         chk("rst_valid", int'(Q_VALID), 0);
         chk("rst_ovf", int'(OVERFLOW), 0);
      end

      // basic packing
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b1);
         if (i < 3) chk("basic_not_yet", int'(Q_VALID), 0);
      end
      chk("basic_39", int'(Q), 'h39);
      chk("basic_valid", int'(Q_VALID), 1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
      chk("basic_ff", int'(Q), 'hFF);
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      chk("basic_consumed", int'(Q_VALID), 0);

      // E gaps
      cyc(1'b1, 1'b1, pat[0], 1'b0, 1'b1);
      cyc(1'b1, 1'b1, pat[1], 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 2'($urandom), 1'b0, 1'b1);
         chk("gap_idle", int'(Q_VALID), 0);
      end
      cyc(1'b1, 1'b1, pat[2], 1'b0, 1'b1);
      chk("gap_3rd", int'(Q_VALID), 0);
      cyc(1'b1, 1'b1, pat[3], 1'b0, 1'b1);
      chk("gap_39", int'(Q), 'h39);
      chk("gap_valid", int'(Q_VALID), 1);
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

      // back-pressure and overflow
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b0);
      chk("bp_first", int'(Q), 'h39);
      chk("bp_valid", int'(Q_VALID), 1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
      chk("bp_held", int'(Q), 'h39);
      chk("bp_ovf", int'(OVERFLOW), 1);
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      chk("bp_drain_valid", int'(Q_VALID), 0);
      chk("bp_drain_q", int'(Q), 'h39);
      chk("bp_ovf_sticky", int'(OVERFLOW), 1);

      // bitslip discards the first pair
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      chk("rst_ovf_clr", int'(OVERFLOW), 0);
      cyc(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
      chk("slip_not_yet", int'(Q_VALID), 0);
      cyc(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
      chk("slip_4e", int'(Q), 'h4E);

      // reset mid-word
      cyc(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, pat[i], 1'b0, 1'b1);
      chk("midrst_39", int'(Q), 'h39);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) != 0),
             ($urandom_range(0, 3) != 0),
             2'($urandom),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 2) != 0));
      end

      // drain and confirm every loaded word was seen
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
      chk("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/i_ddr_deser.md
# i_ddr_deser

Input deserializer that sits directly downstream of the I_DDR input primitive. It consumes the 2-bit per-cycle DDR capture, packs consecutive bit-pairs LSB-first into WIDTH-bit words, and presents each word on a valid/ready output handshake. It also supports pair-granular word alignment (bitslip) and flags words lost to output back-pressure.

## Interface
- WIDTH, 8: output word width; even, 4..16. Each word carries WIDTH/2 pairs.
- C  input  1  clock; same clock that drives the upstream I_DDR.
- R  input  1  reset; synchronous, active-low.
- E  input  1  pair-accept enable; D is consumed only on edges where E=1.
- D  input  2  pair from I_DDR Q. D[0] is the rising-edge bit (earlier), D[1] is the falling-edge bit (later).
- BITSLIP  input  1  single-cycle alignment request; acted on only when E=1.
- Q  output  WIDTH  assembled word.
- Q_VALID  output  1  Q holds an unconsumed word.
- Q_READY  input  1  downstream accepts Q on edges where Q_VALID=1 and Q_READY=1.
- OVERFLOW  output  1  sticky flag: a completed word was dropped.

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0];
  - pair counter cnt, 0..WIDTH/2-1, with width $clog2(WIDTH/2), minimum 1;
  - output register Q, Q_VALID and OVERFLOW.
- Accept, when R=1, E=1 and BITSLIP=0:
  - sr <= {D, sr[WIDTH-1:2]};
  - cnt increments.
- Word completion, on an accepting edge with cnt==WIDTH/2-1:
  - assembled word W = {D, sr[WIDTH-1:2]};
  - cnt wraps to 0;
  - the first accepted pair of the word lands at Q[1:0] and the last at Q[WIDTH-1:WIDTH-2].
- Output load:
  - W is loaded into Q and Q_VALID is set to 1 if Q_VALID=0 or Q_READY=1 on that edge.
  - Otherwise W is discarded, OVERFLOW is set to 1, and Q and Q_VALID are unchanged.
- Consume: if Q_VALID=1, Q_READY=1 and no word completes on that edge, Q_VALID <= 0. Q keeps its last value.
- Hold: while Q_VALID=1 and Q_READY=0, Q is stable.
- Bitslip, with E=1 and BITSLIP=1:
  - the pair on D is discarded;
  - sr and cnt are unchanged;
  - this shifts word alignment by one pair (2 bits) per pulse.
- BITSLIP with E=0 is ignored and not remembered.
- E=0: sr and cnt are held. The output handshake continues normally.
- OVERFLOW clears only on reset.

## Timing
- Reset: on an edge with R=0, Q=0, Q_VALID=0, OVERFLOW=0, sr=0 and cnt=0. Reset overrides E, BITSLIP and Q_READY on that edge.
- Reset mid-word: a partially assembled word is lost. Assembly restarts at pair 0 on the first accepting edge after R=1.
- Latency: Q and Q_VALID update on the same edge that accepts the last pair of a word. They are visible in the cycle after that edge.
- Throughput: with E held at 1 and Q_READY held at 1, one word every WIDTH/2 cycles, with no bubbles.
- Simultaneous consume and complete: on the same edge, the new word replaces the old. Q_VALID stays 1 and OVERFLOW is not set.
- Completion while Q_VALID=1 and Q_READY=0: drop and set OVERFLOW on that edge; cnt still wraps to 0.
- BITSLIP on the edge that would have completed a word: no completion, and cnt stays at WIDTH/2-1.
- No combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold R=0 for 2 cycles with random D, E and BITSLIP → Q=0x00, Q_VALID=0 and OVERFLOW=0 after each edge.
- Basic packing: after R=1, E=1 and Q_READY=1, drive D pairs 01,10,11,00 → Q=0x39 with Q_VALID=1 for one cycle after the 4th edge. Then drive pairs 11,11,11,11 → Q=0xFF.
- Streaming with E gaps: same 4 pairs with E=0 for 3 cycles between pairs 2 and 3 → Q=0x39. Q_VALID rises only after the 4th accepted pair.
- Back-pressure and overflow:
  - Q_READY=0 and 8 pairs streamed → first word held stable with Q_VALID=1;
  - second word dropped and OVERFLOW=1;
  - raising Q_READY clears Q_VALID with Q still showing the first word.
- Bitslip: BITSLIP=1 with E=1 on the first pair, then stream pairs 01,10,11,00,01 → the first pair is discarded and Q=0x4E, i.e. pairs 10,11,00,01 packed.
- Reset mid-word: 2 pairs accepted, R=0 for 1 cycle, then pairs 01,10,11,00 → Q=0x39 with no residue from the earlier pairs.
